// File: rtl/sym_pkg.sv
// Shared constants and sizing helpers for the mirror-symmetry stream detector.
package sym_pkg;

    localparam logic MODE_SYM  = 1'b0;
    localparam logic MODE_ANTI = 1'b1;

    function automatic int pairs(input int w);
        return w / 2;
    endfunction

    function automatic int cnt_width(input int w);
        return $clog2(w / 2 + 1);
    endfunction

endpackage

// File: rtl/sym_popcount.sv
// Combinational adder-tree population count; leaves beyond N are zero padding.
module sym_popcount #(
    parameter int N     = 4,
    parameter int CNT_W = 3
) (
    input  logic [N-1:0]     bits_i,
    output logic [CNT_W-1:0] count_o
);

    localparam int LEVELS = (N > 1) ? $clog2(N) : 0;
    localparam int LEAVES = 1 << LEVELS;

    // Heap layout: node[1] is the root, node[LEAVES..2*LEAVES-1] are the leaves.
    logic [CNT_W-1:0] node [1:2*LEAVES-1];

    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < N) begin : g_bit
            assign node[LEAVES+i] = CNT_W'(bits_i[i]);
        end else begin : g_pad
            assign node[LEAVES+i] = '0;
        end
    end

    for (genvar i = 1; i < LEAVES; i++) begin : g_sum
        assign node[i] = node[2*i] + node[2*i+1];
    end

    assign count_o = node[1];

endmodule

// File: rtl/sym_stream_detector.sv
// Two-stage valid/ready pipeline that scores each word for mirror (anti-)symmetry
// and keeps saturating delivery statistics.
module sym_stream_detector
    import sym_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int CNT_W  = cnt_width(WIDTH),
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_mode,
    input  logic [CNT_W-1:0]  in_tol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sym,
    output logic              out_match,
    output logic [CNT_W-1:0]  out_mismatch,
    input  logic              clear_stats,
    output logic [STAT_W-1:0] frame_cnt,
    output logic [STAT_W-1:0] match_cnt,
    output logic [STAT_W-1:0] run_len
);

    localparam int P = pairs(WIDTH);

    logic              rdy_q;
    logic              s1_valid_q;
    logic [P-1:0]      s1_diff_q;
    logic [P-1:0]      s1_diff_d;
    logic [CNT_W-1:0]  s1_tol_q;
    logic              s2_valid_q;
    logic              s2_sym_q;
    logic              s2_match_q;
    logic [CNT_W-1:0]  s2_mis_q;
    logic [CNT_W-1:0]  pop_cnt;
    logic              s1_adv;
    logic              s2_adv;
    logic              accept;
    logic              deliver;
    logic [STAT_W-1:0] frame_q, frame_d;
    logic [STAT_W-1:0] match_q, match_d;
    logic [STAT_W-1:0] run_q, run_d;

    assign s2_adv   = ~s2_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv & rdy_q;
    assign accept   = in_valid & in_ready;
    assign deliver  = s2_valid_q & out_ready;

    // A set bit marks a pair that violates the requested relationship.
    always_comb begin
        s1_diff_d = '0;
        for (int k = 0; k < P; k++) begin
            s1_diff_d[k] = in_data[k] ^ in_data[WIDTH-1-k] ^ (in_mode == MODE_ANTI);
        end
    end

    sym_popcount #(.N(P), .CNT_W(CNT_W)) u_pop (
        .bits_i  (s1_diff_q),
        .count_o (pop_cnt)
    );

    // Holds in_ready low through the first clock after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_q <= 1'b0;
        else     rdy_q <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_tol_q   <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_diff_q <= s1_diff_d;
                s1_tol_q  <= in_tol;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_mis_q   <= '0;
            s2_sym_q   <= 1'b0;
            s2_match_q <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_mis_q   <= pop_cnt;
                s2_sym_q   <= (pop_cnt == '0);
                s2_match_q <= (pop_cnt <= s1_tol_q);
            end
        end
    end

    // Clear wins over a same-cycle delivery; every counter sticks at all-ones.
    always_comb begin
        frame_d = frame_q;
        match_d = match_q;
        run_d   = run_q;
        if (clear_stats) begin
            frame_d = '0;
            match_d = '0;
            run_d   = '0;
        end else if (deliver) begin
            if (frame_q != '1) frame_d = frame_q + STAT_W'(1);
            if (s2_match_q) begin
                if (match_q != '1) match_d = match_q + STAT_W'(1);
                if (run_q != '1)   run_d   = run_q + STAT_W'(1);
            end else begin
                run_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_q <= '0;
            match_q <= '0;
            run_q   <= '0;
        end else begin
            frame_q <= frame_d;
            match_q <= match_d;
            run_q   <= run_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_sym      = s2_sym_q;
    assign out_match    = s2_match_q;
    assign out_mismatch = s2_mis_q;
    assign frame_cnt    = frame_q;
    assign match_cnt    = match_q;
    assign run_len      = run_q;

endmodule

// File: tb/tb_sym_stream_detector.sv
// Directed bench for sym_stream_detector: widths 8/16/2 plus a 4-bit-stats instance.
module tb_sym_stream_detector;

    typedef struct {
        logic [15:0] data;
        logic        mode;
        logic [3:0]  tol;
        logic        sym;
        int          mis;
        logic        match;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        outReady;
    logic        clearStats;
    logic [15:0] inData;
    logic        inMode;
    logic [3:0]  inTol;
    logic        validMain, validSat, valid16, valid2;

    logic        readyMain, outValidMain, symMain, matchMain;
    logic [2:0]  misMain;
    logic [15:0] frameMain, matchCntMain, runMain;

    logic        readySat, outValidSat, symSat, matchSat;
    logic [2:0]  misSat;
    logic [3:0]  frameSat, matchCntSat, runSat;

    logic        ready16, outValid16, sym16, match16;
    logic [3:0]  mis16;
    logic [15:0] frame16, matchCnt16, run16;

    logic        ready2, outValid2, sym2, match2;
    logic [0:0]  mis2;
    logic [15:0] frame2, matchCnt2, run2;

    int   vecCount  = 0;
    int   missCount = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    sym_stream_detector #(.WIDTH(8), .STAT_W(16)) dutMain (
        .clk(clk), .rst(rst), .in_valid(validMain), .in_ready(readyMain),
        .in_data(inData[7:0]), .in_mode(inMode), .in_tol(inTol[2:0]),
        .out_valid(outValidMain), .out_ready(outReady), .out_sym(symMain),
        .out_match(matchMain), .out_mismatch(misMain), .clear_stats(clearStats),
        .frame_cnt(frameMain), .match_cnt(matchCntMain), .run_len(runMain)
    );

    sym_stream_detector #(.WIDTH(8), .STAT_W(4)) dutSat (
        .clk(clk), .rst(rst), .in_valid(validSat), .in_ready(readySat),
        .in_data(inData[7:0]), .in_mode(inMode), .in_tol(inTol[2:0]),
        .out_valid(outValidSat), .out_ready(outReady), .out_sym(symSat),
        .out_match(matchSat), .out_mismatch(misSat), .clear_stats(clearStats),
        .frame_cnt(frameSat), .match_cnt(matchCntSat), .run_len(runSat)
    );

    sym_stream_detector #(.WIDTH(16), .STAT_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(valid16), .in_ready(ready16),
        .in_data(inData), .in_mode(inMode), .in_tol(inTol),
        .out_valid(outValid16), .out_ready(outReady), .out_sym(sym16),
        .out_match(match16), .out_mismatch(mis16), .clear_stats(clearStats),
        .frame_cnt(frame16), .match_cnt(matchCnt16), .run_len(run16)
    );

    sym_stream_detector #(.WIDTH(2), .STAT_W(16)) dut2 (
        .clk(clk), .rst(rst), .in_valid(valid2), .in_ready(ready2),
        .in_data(inData[1:0]), .in_mode(inMode), .in_tol(inTol[0:0]),
        .out_valid(outValid2), .out_ready(outReady), .out_sym(sym2),
        .out_match(match2), .out_mismatch(mis2), .clear_stats(clearStats),
        .frame_cnt(frame2), .match_cnt(matchCnt2), .run_len(run2)
    );

    function automatic vec_t mk(input logic [15:0] d, input logic m, input logic [3:0] t,
                                input logic s, input int mis, input logic mt);
        vec_t v;
        v.data = d; v.mode = m; v.tol = t; v.sym = s; v.mis = mis; v.match = mt;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic valid);
        case (which)
            0:       validMain = valid;
            1:       valid16   = valid;
            2:       valid2    = valid;
            default: validSat  = valid;
        endcase
    endtask

    task automatic sampleOut(input int which, output logic v, output logic s,
                             output logic m, output int mis, output logic r);
        case (which)
            0:       begin v = outValidMain; s = symMain; m = matchMain; mis = int'(misMain); r = readyMain; end
            1:       begin v = outValid16;   s = sym16;   m = match16;   mis = int'(mis16);   r = ready16;   end
            default: begin v = outValid2;    s = sym2;    m = match2;    mis = int'(mis2);    r = ready2;    end
        endcase
    endtask

    // Streams vecs back-to-back with out_ready high; results must appear two cycles after acceptance.
    task automatic runTable(input int which, input string tag);
        logic v, s, m, r;
        int   mis;
        int   n;
        n = vecs.size();
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            sampleOut(which, v, s, m, mis, r);
            if (i >= 2) begin
                checkOutput($sformatf("%s[%0d] valid", tag, i-2), int'(v), 1);
                checkOutput($sformatf("%s[%0d] sym", tag, i-2), int'(s), int'(vecs[i-2].sym));
                checkOutput($sformatf("%s[%0d] mismatch", tag, i-2), mis, vecs[i-2].mis);
                checkOutput($sformatf("%s[%0d] match", tag, i-2), int'(m), int'(vecs[i-2].match));
            end else begin
                checkOutput($sformatf("%s early valid %0d", tag, i), int'(v), 0);
            end
            if (i < n) begin
                checkOutput($sformatf("%s[%0d] in_ready", tag, i), int'(r), 1);
                inData = vecs[i].data;
                inMode = vecs[i].mode;
                inTol  = vecs[i].tol;
                applyStimulus(which, 1'b1);
            end else begin
                applyStimulus(which, 1'b0);
            end
        end
        @(negedge clk);
        sampleOut(which, v, s, m, mis, r);
        checkOutput($sformatf("%s drained valid", tag), int'(v), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] bpData [3];
        logic       bpMode [3];
        int         bpMis  [3];
        int         wi, accepted, got;

        rst = 1'b1; outReady = 1'b1; clearStats = 1'b0;
        inData = '0; inMode = 1'b0; inTol = '0;
        validMain = 1'b0; validSat = 1'b0; valid16 = 1'b0; valid2 = 1'b0;

        // Reset state, then in_ready only after the first clock following release.
        repeat (2) @(negedge clk);
        checkOutput("reset out_valid", int'(outValidMain), 0);
        checkOutput("reset in_ready", int'(readyMain), 0);
        checkOutput("reset frame_cnt", int'(frameMain), 0);
        checkOutput("reset mismatch", int'(misMain), 0);
        rst = 1'b0;
        #1;
        checkOutput("release in_ready before edge", int'(readyMain), 0);
        @(negedge clk);
        checkOutput("release in_ready after edge", int'(readyMain), 1);

        // Symmetric, anti-symmetric and tolerance vectors at WIDTH=8.
        vecs.delete();
        vecs.push_back(mk(16'h81, 1'b0, 4'd0, 1'b1, 0, 1'b1));
        vecs.push_back(mk(16'h01, 1'b0, 4'd0, 1'b0, 1, 1'b0));
        vecs.push_back(mk(16'hF0, 1'b0, 4'd0, 1'b0, 4, 1'b0));
        vecs.push_back(mk(16'h0F, 1'b1, 4'd0, 1'b1, 0, 1'b1));
        vecs.push_back(mk(16'hFF, 1'b1, 4'd0, 1'b0, 4, 1'b0));
        vecs.push_back(mk(16'h03, 1'b0, 4'd1, 1'b0, 2, 1'b0));
        vecs.push_back(mk(16'h03, 1'b0, 4'd2, 1'b0, 2, 1'b1));
        vecs.push_back(mk(16'hF0, 1'b0, 4'd4, 1'b0, 4, 1'b1));
        vecs.push_back(mk(16'h0F, 1'b0, 4'd7, 1'b0, 4, 1'b1));
        vecs.push_back(mk(16'h3C, 1'b0, 4'd0, 1'b1, 0, 1'b1));
        vecs.push_back(mk(16'h0E, 1'b1, 4'd1, 1'b0, 1, 1'b1));
        runTable(0, "w8");

        // Backpressure: only two words fit, held output stays put, then all three drain in order.
        bpData[0] = 8'h81; bpMode[0] = 1'b0; bpMis[0] = 0;
        bpData[1] = 8'h42; bpMode[1] = 1'b1; bpMis[1] = 4;
        bpData[2] = 8'h18; bpMode[2] = 1'b0; bpMis[2] = 0;
        wi = 0; accepted = 0; got = 0;
        inTol = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            outReady = 1'b0;
            if (c >= 2) begin
                checkOutput($sformatf("bp hold valid c%0d", c), int'(outValidMain), 1);
                checkOutput($sformatf("bp hold mismatch c%0d", c), int'(misMain), bpMis[0]);
                checkOutput($sformatf("bp hold sym c%0d", c), int'(symMain), 1);
            end
            inData = {8'h00, bpData[wi]}; inMode = bpMode[wi]; validMain = 1'b1;
            #1;
            checkOutput($sformatf("bp in_ready c%0d", c), int'(readyMain), int'(c < 2));
            if (readyMain) begin
                accepted++;
                wi++;
            end
        end
        checkOutput("bp accepted while stalled", accepted, 2);
        @(negedge clk);
        outReady = 1'b1;
        inData = {8'h00, bpData[wi]}; inMode = bpMode[wi]; validMain = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (outValidMain) begin
                if (got < 3) begin
                    checkOutput($sformatf("bp drain[%0d] mismatch", got), int'(misMain), bpMis[got]);
                    checkOutput($sformatf("bp drain[%0d] sym", got), int'(symMain), int'(bpMis[got] == 0));
                end
                got++;
            end
            if (validMain && readyMain) begin
                wi++;
                accepted++;
            end
            @(negedge clk);
            if (wi >= 3) validMain = 1'b0;
            else begin
                inData = {8'h00, bpData[wi]}; inMode = bpMode[wi];
            end
        end
        checkOutput("bp results delivered", got, 3);
        checkOutput("bp total accepted", accepted, 3);

        // Statistics: match, match, miss, match.
        @(negedge clk); clearStats = 1'b1;
        @(negedge clk); clearStats = 1'b0;
        checkOutput("clear frame_cnt", int'(frameMain), 0);
        checkOutput("clear match_cnt", int'(matchCntMain), 0);
        vecs.delete();
        vecs.push_back(mk(16'h81, 1'b0, 4'd0, 1'b1, 0, 1'b1));
        vecs.push_back(mk(16'h3C, 1'b0, 4'd0, 1'b1, 0, 1'b1));
        vecs.push_back(mk(16'h01, 1'b0, 4'd0, 1'b0, 1, 1'b0));
        vecs.push_back(mk(16'h18, 1'b0, 4'd0, 1'b1, 0, 1'b1));
        runTable(0, "stats");
        checkOutput("stats frame_cnt", int'(frameMain), 4);
        checkOutput("stats match_cnt", int'(matchCntMain), 3);
        checkOutput("stats run_len", int'(runMain), 1);

        // Clear coinciding with a delivery handshake.
        @(negedge clk); inData = 16'h81; inMode = 1'b0; inTol = '0; validMain = 1'b1;
        @(negedge clk); validMain = 1'b0;
        @(negedge clk);
        checkOutput("clear-hs out_valid", int'(outValidMain), 1);
        clearStats = 1'b1;
        @(negedge clk); clearStats = 1'b0;
        checkOutput("clear-hs frame_cnt", int'(frameMain), 0);
        checkOutput("clear-hs match_cnt", int'(matchCntMain), 0);
        checkOutput("clear-hs run_len", int'(runMain), 0);
        checkOutput("clear-hs consumed", int'(outValidMain), 0);

        // Saturation of 4-bit counters after 20 matching deliveries.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); inData = 16'h81; inMode = 1'b0; inTol = '0; validSat = 1'b1;
        end
        @(negedge clk); validSat = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("sat frame_cnt", int'(frameSat), 15);
        checkOutput("sat match_cnt", int'(matchCntSat), 15);
        checkOutput("sat run_len", int'(runSat), 15);

        // Reset with two words in flight.
        @(negedge clk); inData = 16'h81; validMain = 1'b1;
        @(negedge clk); validMain = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pre-reset frame_cnt", int'(frameMain), 1);
        outReady = 1'b0;
        inData = 16'h01; validMain = 1'b1;
        @(negedge clk); inData = 16'hF0;
        @(negedge clk); validMain = 1'b0;
        checkOutput("pre-reset in flight", int'(outValidMain), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("mid-reset out_valid", int'(outValidMain), 0);
        checkOutput("mid-reset frame_cnt", int'(frameMain), 0);
        checkOutput("mid-reset match_cnt", int'(matchCntMain), 0);
        checkOutput("mid-reset run_len", int'(runMain), 0);
        @(negedge clk); rst = 1'b0; outReady = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("post-reset stale c%0d", c), int'(outValidMain), 0);
        end
        vecs.delete();
        vecs.push_back(mk(16'h01, 1'b0, 4'd0, 1'b0, 1, 1'b0));
        runTable(0, "post-reset");

        // WIDTH=16.
        vecs.delete();
        vecs.push_back(mk(16'h8001, 1'b0, 4'd0, 1'b1, 0, 1'b1));
        vecs.push_back(mk(16'h0001, 1'b0, 4'd0, 1'b0, 1, 1'b0));
        vecs.push_back(mk(16'hFF00, 1'b0, 4'd0, 1'b0, 8, 1'b0));
        vecs.push_back(mk(16'h00FF, 1'b1, 4'd0, 1'b1, 0, 1'b1));
        vecs.push_back(mk(16'hFFFF, 1'b1, 4'd0, 1'b0, 8, 1'b0));
        vecs.push_back(mk(16'h0003, 1'b0, 4'd1, 1'b0, 2, 1'b0));
        vecs.push_back(mk(16'h0003, 1'b0, 4'd2, 1'b0, 2, 1'b1));
        vecs.push_back(mk(16'hFF00, 1'b0, 4'd8, 1'b0, 8, 1'b1));
        runTable(1, "w16");

        // WIDTH=2.
        vecs.delete();
        vecs.push_back(mk(16'h3, 1'b0, 4'd0, 1'b1, 0, 1'b1));
        vecs.push_back(mk(16'h1, 1'b0, 4'd0, 1'b0, 1, 1'b0));
        vecs.push_back(mk(16'h1, 1'b1, 4'd0, 1'b1, 0, 1'b1));
        vecs.push_back(mk(16'h0, 1'b1, 4'd0, 1'b0, 1, 1'b0));
        vecs.push_back(mk(16'h2, 1'b0, 4'd1, 1'b0, 1, 1'b1));
        runTable(2, "w2");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
